axi_rd_burst_ctrl: RTL

AXI_RD_BURST_CTRL -- requirements
Module: axi_rd_burst_ctrl

---
 rtl/axi_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/axi_rd_burst_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and controller state type for the read burst controller.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } ctrl_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head entry is visible on dout_o
// whenever empty_o is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  assign empty_o = (wr_q == rd_q);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_i) begin
      mem_d[wr_q[AW-1:0]] = din_i;
      wr_d = wr_q + PTR_ONE;
    end
    if (pop_i && !empty_o) begin
      rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read burst controller: expands AR bursts into per-beat RAM reads and
// returns RAM data on the R channel through a credit-limited response buffer.
module axi_rd_burst_ctrl
  import axi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ADDRS = 32,
  parameter int IDS   = 4,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             axi_arvalid_i,
  output logic             axi_arready_o,
  input  logic [ADDRS-1:0] axi_araddr_i,
  input  logic [IDS-1:0]   axi_arid_i,
  input  logic [7:0]       axi_arlen_i,
  input  logic [1:0]       axi_arburst_i,
  output logic             axi_rvalid_o,
  input  logic             axi_rready_i,
  output logic             axi_rlast_o,
  output logic [1:0]       axi_rresp_o,
  output logic [IDS-1:0]   axi_rid_o,
  output logic [WIDTH-1:0] axi_rdata_o,
  output logic             ram_rden_o,
  output logic [ADDRS-1:0] ram_addr_o,
  input  logic             ram_accept_i,
  input  logic             ram_valid_i,
  input  logic             ram_error_i,
  input  logic [WIDTH-1:0] ram_rddata_i,
  output logic             proto_err_o
);

  // state    | meaning
  // ST_IDLE  | waiting for an AR handshake, arready high
  // ST_BURST | one RAM request per beat until the last one is accepted

  localparam int BYTES = WIDTH / 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TAG_W = IDS + 2;
  localparam int RSP_W = WIDTH + IDS + 3;

  localparam logic [ADDRS-1:0] STEP      = ADDRS'(BYTES);
  localparam logic [ADDRS-1:0] BEAT_MASK = ADDRS'(BYTES - 1);
  localparam logic [ADDRS-1:0] ADDR_ONE  = ADDRS'(1);
  localparam logic [CW-1:0]    CREDIT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0]    CREDIT_ONE = CW'(1);

  ctrl_state_e      state_q, state_d;
  logic [ADDRS-1:0] addr_q, addr_d;
  logic [IDS-1:0]   id_q, id_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       beats_q, beats_d;
  burst_e           burst_q, burst_d;
  logic             err_q, err_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic             proto_err_q, proto_err_d;

  logic             take;
  logic             r_hs;
  logic             tag_empty;
  logic [TAG_W-1:0] tag_din, tag_dout;
  logic             rsp_empty, rsp_push;
  logic [RSP_W-1:0] rsp_din, rsp_dout;
  logic [ADDRS-1:0] wrap_mask, addr_inc, addr_next;
  logic [IDS-1:0]   tag_id;
  logic             tag_last, tag_err;

  assign axi_arready_o = (state_q == ST_IDLE);
  assign ram_rden_o    = (state_q == ST_BURST) && (credit_q != '0);
  assign ram_addr_o    = addr_q;
  assign proto_err_o   = proto_err_q;

  assign take = ram_rden_o & ram_accept_i;
  assign r_hs = axi_rvalid_o & axi_rready_i;

  assign wrap_mask = (ADDRS'(len_q) + ADDR_ONE) * STEP - ADDR_ONE;
  assign addr_inc  = addr_q + STEP;

  always_comb begin
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     addr_next = addr_inc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    beats_d = beats_q;
    burst_d = burst_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (axi_arvalid_i) begin
          state_d = ST_BURST;
          addr_d  = axi_araddr_i & ~BEAT_MASK;
          id_d    = axi_arid_i;
          len_d   = axi_arlen_i;
          beats_d = axi_arlen_i;
          burst_d = BURST_INCR;
          err_d   = 1'b0;
          case (burst_e'(axi_arburst_i))
            BURST_FIXED: burst_d = BURST_FIXED;
            BURST_INCR:  burst_d = BURST_INCR;
            BURST_WRAP: begin
              if (wrap_len_ok(axi_arlen_i)) begin
                burst_d = BURST_WRAP;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_BURST: begin
        if (take) begin
          if (beats_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            beats_d = beats_q - 8'd1;
            addr_d  = addr_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A credit is one buffer slot reserved from request issue until the R pop.
  always_comb begin
    credit_d = credit_q;
    if (take && !r_hs) begin
      credit_d = credit_q - CREDIT_ONE;
    end else if (!take && r_hs) begin
      credit_d = credit_q + CREDIT_ONE;
    end
  end

  assign proto_err_d = proto_err_q | (ram_valid_i & tag_empty);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      id_q        <= '0;
      len_q       <= '0;
      beats_q     <= '0;
      burst_q     <= BURST_FIXED;
      err_q       <= 1'b0;
      credit_q    <= CREDIT_MAX;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      len_q       <= len_d;
      beats_q     <= beats_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      credit_q    <= credit_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign tag_din = {id_q, (beats_q == 8'd0), err_q};
  assign {tag_id, tag_last, tag_err} = tag_dout;

  sync_fifo #(
    .WIDTH(TAG_W),
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (take),
    .din_i  (tag_din),
    .pop_i  (ram_valid_i),
    .dout_o (tag_dout),
    .empty_o(tag_empty)
  );

  // Returns with nothing in flight have no tag and are dropped here.
  assign rsp_push = ram_valid_i & ~tag_empty;
  assign rsp_din  = {ram_rddata_i, tag_id, tag_last,
                     (ram_error_i | tag_err) ? RESP_SLVERR : RESP_OKAY};

  sync_fifo #(
    .WIDTH(RSP_W),
    .DEPTH(DEPTH)
  ) u_rsp_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (rsp_push),
    .din_i  (rsp_din),
    .pop_i  (r_hs),
    .dout_o (rsp_dout),
    .empty_o(rsp_empty)
  );

  assign axi_rvalid_o = ~rsp_empty;
  assign {axi_rdata_o, axi_rid_o, axi_rlast_o, axi_rresp_o} = rsp_dout;

endmodule
